ahb_lite_master_cdl: RTL
========================

AHB_LITE_MASTER_CDL -- requirements
Module: ahb_lite_master_cdl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of consecutive hready-low cycles tolerated per transfer; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 cmd_valid  input  1  a command is presented.
REQ-005 cmd_ready  output  1  the block accepts a command this cycle.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  4  target register address.
REQ-008 cmd_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle pulse marking command completion.
REQ-011 rsp_rdata  output  32  read data, size-masked; valid with rsp_valid.
REQ-012 rsp_error  output  1  completion was an error; valid with rsp_valid.
REQ-013 hsel, hwrite  output  1 each  AHB-Lite select and direction.
REQ-014 haddr  output  4; htrans  output  2; hsize  output  2; hwdata  output  32: AHB-Lite address and data phase.
REQ-015 hrdata  input  32; hready  input  1; hresp  input  1: responder return signals.
REQ-016 xfer_count  output  8  count of completed commands, error or not; wraps 255 -> 0.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, DATA, ERR and SHALL accept one outstanding command at a time.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid=1 and cmd_ready=1, and all cmd_* fields are latched on that edge.
REQ-019 An accepted command with cmd_size=3 SHALL produce no bus activity: it returns to IDLE, and rsp_valid=1 with rsp_error=1 is asserted the next cycle.
REQ-020 Otherwise the FSM SHALL go to ADDR and drive hsel=1, htrans=2'b10, and the latched haddr, hsize and hwrite.
REQ-021 ADDR SHALL hold all address-phase outputs unchanged while hready=0; on the first edge with hready=1 it SHALL move to DATA.
REQ-022 DATA SHALL drive hsel=0, htrans=2'b00 and, for writes, hwdata=latched wdata, held stable until the transfer completes.
REQ-023 DATA with hready=1 and hresp=0 SHALL complete the command: next cycle rsp_valid=1 and rsp_error=0; for reads, rsp_rdata=hrdata masked to the low 8, 16 or 32 bits for size 0, 1 or 2; the FSM returns to IDLE.
REQ-024 DATA with hresp=1 SHALL move to ERR; ERR completes on the first edge with hready=1, whatever hresp is then, giving rsp_valid=1, rsp_error=1 and rsp_rdata=0.
REQ-025 The wait counter SHALL clear on entry to ADDR and on ADDR->DATA, and SHALL increment on each hready=0 cycle in ADDR, DATA or ERR.
REQ-026 When the wait counter reaches TIMEOUT, the FSM SHALL complete the command with rsp_error=1, drive htrans=2'b00 and hsel=0, and return to IDLE.
REQ-027 rsp_valid SHALL be high for exactly one cycle per accepted command; rsp_rdata and rsp_error SHALL hold their values until the next completion.
REQ-028 xfer_count SHALL increment by 1 in the cycle rsp_valid=1.
REQ-029 A cmd_valid arriving while the block is busy SHALL be ignored, with no effect on the bus.

Reset
REQ-030 While rst=1 the block SHALL be in IDLE and all outputs SHALL be 0 (cmd_ready=0, htrans=2'b00, hsel=0, haddr/hsize/hwdata=0, rsp_*=0, xfer_count=0).
REQ-031 Assertion of rst mid-transfer SHALL abandon the transfer without a response.
REQ-032 cmd_ready=1 SHALL appear on the first rising edge after rst deasserts.

Verification
REQ-033 Word write, addr 0x0, wdata 0xA5A5_1234, hready always 1 -> ADDR 1 cycle with htrans=10, hwrite=1, hsize=2; DATA hwdata=0xA5A5_1234; rsp_valid next cycle, rsp_error=0, xfer_count=1.
REQ-034 Byte read, addr 0x8, responder holds hready=0 for 3 DATA cycles then returns hrdata=0xFFFF_FF42 -> rsp_rdata=0x0000_0042, rsp_error=0.
REQ-035 Read from addr 0x9, responder gives hresp=1 with hready=0, then hready=1 with hresp=0 -> ERR entered, rsp_valid with rsp_error=1, rsp_rdata=0.
REQ-036 hready stuck at 0 with TIMEOUT=4 -> after 4 wait cycles rsp_error=1, htrans=00, FSM back in IDLE with cmd_ready=1.
REQ-037 cmd_size=3 -> no htrans=10 cycle; rsp_error=1 pulse; then 256 legal commands -> xfer_count wraps to 1.
REQ-038 rst pulsed during DATA of a halfword write -> all outputs 0, no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/ahb_lite_master_cdl.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_cdl
//   Single-outstanding AHB-Lite master. A command (read/write, 4-bit address,
//   byte/halfword/word size) is accepted in IDLE. It is run as one AHB-Lite
//   transfer: an address phase, a data phase, and an optional two-cycle error
//   response. Completion produces a one-cycle rsp_valid pulse. Every state
//   with hready low counts wait cycles. The transfer is abandoned with an
//   error once TIMEOUT consecutive wait cycles have been seen.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_write/addr/size/wdata   command fields, latched on acceptance
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         size-masked read data (0 on error), held until next rsp
//   rsp_error         completion status, held until next rsp
//   hsel, hwrite, haddr, htrans, hsize, hwdata   AHB-Lite master outputs
//   hrdata, hready, hresp                        AHB-Lite responder inputs
//   xfer_count        completed-command counter, wraps at 256
// ---------------------------------------------------------------------------
module ahb_lite_master_cdl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [3:0]  cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic        hsel,
   output logic        hwrite,
   output logic [3:0]  haddr,
   output logic [1:0]  htrans,
   output logic [1:0]  hsize,
   output logic [31:0] hwdata,
   input  logic [31:0] hrdata,
   input  logic        hready,
   input  logic        hresp,
   output logic [7:0]  xfer_count
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [31:0] wdata_q;
   logic [31:0] rd_mask;
   logic        timeout_hit;

   // hsize holds the latched command size for the whole transfer.
   // timeout_hit flags the edge that would be the TIMEOUT-th wait cycle.
   always_comb begin
      rd_mask = '1;
      unique case (hsize)
         2'd0:    rd_mask = 32'h0000_00FF;
         2'd1:    rd_mask = 32'h0000_FFFF;
         default: rd_mask = '1;
      endcase
      timeout_hit = !hready && (wait_cnt == 8'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_error  <= 1'b0;
         hsel       <= 1'b0;
         hwrite     <= 1'b0;
         haddr      <= '0;
         htrans     <= 2'b00;
         hsize      <= '0;
         hwdata     <= '0;
         xfer_count <= '0;
         wait_cnt   <= '0;
         wdata_q    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  haddr   <= cmd_addr;
                  hsize   <= cmd_size;
                  hwrite  <= cmd_write;
                  wdata_q <= cmd_wdata;
                  if (cmd_size == 2'd3) begin
                     // illegal size: answered immediately, bus untouched
                     rsp_valid  <= 1'b1;
                     rsp_error  <= 1'b1;
                     rsp_rdata  <= '0;
                     xfer_count <= xfer_count + 8'd1;
                  end else begin
                     state     <= ADDR;
                     cmd_ready <= 1'b0;
                     hsel      <= 1'b1;
                     htrans    <= 2'b10;
                     wait_cnt  <= '0;
                  end
               end
            end

            ADDR: begin
               if (timeout_hit) begin
                  state      <= IDLE;
                  cmd_ready  <= 1'b1;
                  hsel       <= 1'b0;
                  htrans     <= 2'b00;
                  rsp_valid  <= 1'b1;
                  rsp_error  <= 1'b1;
                  rsp_rdata  <= '0;
                  xfer_count <= xfer_count + 8'd1;
               end else if (hready) begin
                  state    <= DATA;
                  hsel     <= 1'b0;
                  htrans   <= 2'b00;
                  wait_cnt <= '0;
                  hwdata   <= hwrite ? wdata_q : '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end

            DATA: begin
               if (timeout_hit) begin
                  state      <= IDLE;
                  cmd_ready  <= 1'b1;
                  rsp_valid  <= 1'b1;
                  rsp_error  <= 1'b1;
                  rsp_rdata  <= '0;
                  xfer_count <= xfer_count + 8'd1;
               end else if (hresp) begin
                  // first cycle of the two-cycle error response
                  state <= ERR;
                  if (!hready) wait_cnt <= wait_cnt + 8'd1;
               end else if (hready) begin
                  state      <= IDLE;
                  cmd_ready  <= 1'b1;
                  rsp_valid  <= 1'b1;
                  rsp_error  <= 1'b0;
                  rsp_rdata  <= hwrite ? '0 : (hrdata & rd_mask);
                  xfer_count <= xfer_count + 8'd1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end

            ERR: begin
               if (hready || timeout_hit) begin
                  state      <= IDLE;
                  cmd_ready  <= 1'b1;
                  rsp_valid  <= 1'b1;
                  rsp_error  <= 1'b1;
                  rsp_rdata  <= '0;
                  xfer_count <= xfer_count + 8'd1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
